// File: rtl/power_seq_cfg.sv
// Power-up sequencer with a serial configuration port.
// A framed serial word (LSB first) sets per-channel gains. A frame with the
// exact bit count releases the VCO reset, then each channel reset in
// ascending order, then raises o_ready. A frame with any other bit count
// sets o_cfg_err and leaves every reset asserted.
//
// state      | meaning
// -----------+--------------------------------------------------------
// S_IDLE     | no sequence running, waiting for a frame
// S_SHIFT    | frame open, shifting serial bits into the shadow
// S_VCO_WAIT | frame accepted, counting down to the VCO reset release
// S_CH_REL   | releasing channel resets one at a time
// S_RDY_WAIT | all channels released, counting down to o_ready
// S_READY    | sequence complete, holding until reset or a new frame
module power_seq_cfg #(
  parameter int N_CH    = 2,
  parameter int GW      = 3,
  parameter int VCO_DLY = 2,
  parameter int CH_DLY  = 10,
  parameter int RDY_DLY = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_sclk,
  input  logic               i_sdin,
  input  logic               i_sen,
  output logic [N_CH*GW-1:0] o_gain,
  output logic [N_CH-1:0]    o_resetb,
  output logic               o_resetbvco,
  output logic               o_ready,
  output logic               o_cfg_err
);

  localparam int NB   = N_CH * GW;
  localparam int CNTW = $clog2(NB + 2);
  localparam int MAXD = (VCO_DLY > CH_DLY) ? ((VCO_DLY > RDY_DLY) ? VCO_DLY : RDY_DLY)
                                           : ((CH_DLY > RDY_DLY) ? CH_DLY : RDY_DLY);
  localparam int TW   = $clog2(MAXD + 1);
  localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(NB);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(NB + 1);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(N_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_VCO_WAIT, S_CH_REL, S_RDY_WAIT, S_READY
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sclk_q;
  logic [1:0]        sdin_q;
  logic [2:0]        sen_q;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [NB-1:0]     shadow_q, shadow_d;
  logic [NB-1:0]     gain_q, gain_d;
  logic [N_CH-1:0]   resetb_q, resetb_d;
  logic              vco_q, vco_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [CHW-1:0]    ch_q, ch_d;

  // bit [1] of each chain is the synchronised signal, bit [2] its previous value
  logic sclk_rise, sen_s, sen_rise, sen_fall, sdin_s, tmr_zero, enter_shift;
  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sen_s       = sen_q[1];
  assign sen_rise    = sen_q[1] & ~sen_q[2];
  assign sen_fall    = ~sen_q[1] & sen_q[2];
  assign sdin_s      = sdin_q[1];
  assign tmr_zero    = (tmr_q == '0);
  assign enter_shift = (state_q != S_SHIFT) && (state_d == S_SHIFT);

  // State, synchronisers and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      sclk_q   <= '0;
      sdin_q   <= '0;
      sen_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      gain_q   <= '0;
      resetb_q <= '0;
      vco_q    <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      tmr_q    <= '0;
      ch_q     <= '0;
    end else begin
      state_q  <= state_d;
      sclk_q   <= {sclk_q[1:0], i_sclk};
      sdin_q   <= {sdin_q[0], i_sdin};
      sen_q    <= {sen_q[1:0], i_sen};
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      gain_q   <= gain_d;
      resetb_q <= resetb_d;
      vco_q    <= vco_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      tmr_q    <= tmr_d;
      ch_q     <= ch_d;
    end
  end

  // Next-state selection; a new frame pre-empts any running sequence
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (sen_rise) state_d = S_SHIFT;
      S_SHIFT:    if (sen_fall) state_d = (cnt_q == CNT_FULL) ? S_VCO_WAIT : S_IDLE;
      S_VCO_WAIT: if (sen_rise) state_d = S_SHIFT;
                  else if (tmr_zero) state_d = S_CH_REL;
      S_CH_REL:   if (sen_rise) state_d = S_SHIFT;
                  else if (tmr_zero && (ch_q == CH_LAST)) state_d = S_RDY_WAIT;
      S_RDY_WAIT: if (sen_rise) state_d = S_SHIFT;
                  else if (tmr_zero) state_d = S_READY;
      S_READY:    if (sen_rise) state_d = S_SHIFT;
      default:    state_d = S_IDLE;
    endcase
  end

  // Shift, accept/reject, delay countdown and release outputs
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    gain_d   = gain_q;
    resetb_d = resetb_q;
    vco_d    = vco_q;
    ready_d  = ready_q;
    err_d    = err_q;
    tmr_d    = tmr_q;
    ch_d     = ch_q;
    if (enter_shift) begin
      // shadow is cleared so each bit can be OR-ed into its slot
      cnt_d    = '0;
      shadow_d = '0;
      err_d    = 1'b0;
      resetb_d = '0;
      vco_d    = 1'b0;
      ready_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          if (sen_fall) begin
            if (cnt_q == CNT_FULL) begin
              gain_d = shadow_q;
              tmr_d  = TW'(VCO_DLY - 1);
            end else begin
              err_d = 1'b1;
            end
          end else if (sclk_rise && sen_s) begin
            if (cnt_q < CNT_FULL) shadow_d = shadow_q | (NB'(sdin_s) << cnt_q);
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNTW'(1);
          end
        end
        S_VCO_WAIT: begin
          if (tmr_zero) begin
            vco_d = 1'b1;
            tmr_d = TW'(CH_DLY - 1);
            ch_d  = '0;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        S_CH_REL: begin
          if (tmr_zero) begin
            resetb_d = resetb_q | (N_CH'(1'b1) << ch_q);
            if (ch_q == CH_LAST) begin
              tmr_d = TW'(RDY_DLY - 1);
            end else begin
              ch_d  = ch_q + CHW'(1);
              tmr_d = TW'(CH_DLY - 1);
            end
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        S_RDY_WAIT: begin
          if (tmr_zero) ready_d = 1'b1;
          else          tmr_d   = tmr_q - TW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_gain      = gain_q;
  assign o_resetb    = resetb_q;
  assign o_resetbvco = vco_q;
  assign o_ready     = ready_q;
  assign o_cfg_err   = err_q;

endmodule

// File: tb/tb_power_seq_cfg.sv
// Bench for power_seq_cfg at default parameters. Expected output changes
// are queued as each frame is driven; a negedge monitor pops one entry per
// observed change and checks value, spacing from the previous change and
// latency from the last raw i_sen rise.
module tb_power_seq_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       sdin = 1'b0;
  logic       sen = 1'b0;
  logic [5:0] gain;
  logic [1:0] resetb;
  logic       vco, rdy, err;

  power_seq_cfg dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_sclk      (sclk),
    .i_sdin      (sdin),
    .i_sen       (sen),
    .o_gain      (gain),
    .o_resetb    (resetb),
    .o_resetbvco (vco),
    .o_ready     (rdy),
    .o_cfg_err   (err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [10:0] val;
    int          dly;
    int          lat;
    string       tag;
  } ev_t;

  ev_t         q[$];
  ev_t         e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_chg = 0;
  int          mark_cyc = 0;
  bit          mon_en = 1'b0;
  logic [10:0] prev_snap = '0;
  logic [10:0] snap;

  localparam logic [5:0] G1 = 6'b011001;
  localparam logic [5:0] G2 = 6'b100110;
  localparam logic [5:0] G3 = 6'b010101;
  localparam logic [5:0] G4 = 6'b111000;
  localparam logic [5:0] G5 = 6'b001011;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] pk(logic [5:0] g, logic [1:0] rb, logic v, logic r, logic er);
    return {g, rb, v, r, er};
  endfunction

  task automatic push(input logic [10:0] val, input int dly, input int lat, input string tag);
    ev_t x;
    x.val = val; x.dly = dly; x.lat = lat; x.tag = tag;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      snap = {gain, resetb, vco, rdy, err};
      if (snap !== prev_snap) begin
        checks++;
        assert (q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_change obs=%b exp=no_change", snap);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          checks++;
          assert (snap === e.val) else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b", e.tag, snap, e.val);
          end
          if (e.dly >= 0) begin
            checks++;
            assert ((cyc - last_chg) == e.dly) else begin
              failures++;
              $error("FAIL %s_dly obs=%0d exp=%0d", e.tag, cyc - last_chg, e.dly);
            end
          end
          if (e.lat >= 0) begin
            checks++;
            assert ((cyc - mark_cyc) <= e.lat) else begin
              failures++;
              $error("FAIL %s_lat obs=%0d exp=<=%0d", e.tag, cyc - mark_cyc, e.lat);
            end
          end
        end
        last_chg  = cyc;
        prev_snap = snap;
      end
    end
  end

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_empty(input int limit, input string tag);
    for (int i = 0; i < limit && q.size() != 0; i++) @(negedge clk);
    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL %s_timeout obs=%0d_pending exp=0_pending", tag, q.size());
      q.delete();
    end
  endtask

  task automatic send_frame(input logic [7:0] bits, input int n);
    mark_cyc = cyc;
    sen = 1'b1;
    #120;
    for (int i = 0; i < n; i++) begin
      sdin = bits[i];
      #60 sclk = 1'b1;
      #60 sclk = 1'b0;
    end
    #60 sen = 1'b0;
    #120;
  endtask

  task automatic sclk_idle(input int edges);
    for (int i = 0; i < edges; i++) begin
      sdin = i[0];
      #60 sclk = ~sclk;
    end
  endtask

  // Queue a valid frame's events (up to nev release steps) and drive it
  task automatic frame_ok(input logic [5:0] gnew, input logic [5:0] gold,
                          input bit from_ready, input bit clr_err, input int nev);
    if (from_ready) push(pk(gold, 2'b00, 1'b0, 1'b0, 1'b0), -1, 4, "drop");
    if (clr_err)    push(pk(gold, 2'b00, 1'b0, 1'b0, 1'b0), -1, 4, "err_clr");
    push(pk(gnew, 2'b00, 1'b0, 1'b0, 1'b0), -1, -1, "accept");
    if (nev >= 1) push(pk(gnew, 2'b00, 1'b1, 1'b0, 1'b0), 2, -1, "vco");
    if (nev >= 2) push(pk(gnew, 2'b01, 1'b1, 1'b0, 1'b0), 10, -1, "rb0");
    if (nev >= 3) push(pk(gnew, 2'b11, 1'b1, 1'b0, 1'b0), 10, -1, "rb1");
    if (nev >= 4) push(pk(gnew, 2'b11, 1'b1, 1'b1, 1'b0), 10, -1, "ready");
    send_frame({2'b00, gnew}, 6);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("reset_state", {gain, resetb, vco, rdy, err}, 11'b0);
    rst = 1'b0;
    prev_snap = 11'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // serial clock with i_sen low is ignored
    sclk_idle(20);
    repeat (5) @(negedge clk);
    check("idle_sclk", {gain, resetb, vco, rdy, err}, 11'b0);

    // short frame rejected
    push(pk(6'b0, 2'b00, 1'b0, 1'b0, 1'b1), -1, -1, "short_err");
    send_frame(8'b00010101, 5);
    wait_empty(50, "short");
    repeat (40) @(negedge clk);
    check("short_hold", {gain, resetb, vco, rdy, err}, pk(6'b0, 2'b00, 1'b0, 1'b0, 1'b1));

    // valid frame clears the error and sequences
    frame_ok(G1, 6'b0, 1'b0, 1'b1, 4);
    wait_empty(200, "valid1");

    // long frame in READY drops everything and is rejected
    push(pk(G1, 2'b00, 1'b0, 1'b0, 1'b0), -1, 4, "long_drop");
    push(pk(G1, 2'b00, 1'b0, 1'b0, 1'b1), -1, -1, "long_err");
    send_frame(8'b01011011, 7);
    wait_empty(50, "long");
    repeat (60) @(negedge clk);
    check("long_no_seq", {gain, resetb, vco, rdy, err}, pk(G1, 2'b00, 1'b0, 1'b0, 1'b1));

    // recovery from error, then re-frame in READY
    frame_ok(G2, G1, 1'b0, 1'b1, 4);
    wait_empty(200, "valid2");
    frame_ok(G3, G2, 1'b1, 1'b0, 4);
    wait_empty(200, "reframe");

    // reset in CH_REL with o_resetb=01
    frame_ok(G4, G3, 1'b1, 1'b0, 2);
    wait_empty(200, "pre_reset");
    check("pre_reset_rb", {gain, resetb, vco, rdy, err}, pk(G4, 2'b01, 1'b1, 1'b0, 1'b0));
    push(11'b0, -1, -1, "mid_reset");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_empty(5, "mid_reset");
    sclk_idle(20);
    repeat (80) @(negedge clk);
    check("post_reset_hold", {gain, resetb, vco, rdy, err}, 11'b0);

    // a valid frame after reset sequences normally
    frame_ok(G5, 6'b0, 1'b0, 1'b0, 4);
    wait_empty(200, "valid_after_reset");
    repeat (20) @(negedge clk);
    check("final_state", {gain, resetb, vco, rdy, err}, pk(G5, 2'b11, 1'b1, 1'b1, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
